// File: rtl/sb_ccff_loader_if.sv
// Host-side streams of the configuration-chain loader: bitstream words in, readback words out.
interface sb_ccff_loader_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;

  modport master (
    output cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid
  );

  modport slave (
    input  cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/sb_ccff_loader.sv
// Serializes host words onto a switch-block configuration chain and returns
// the bits that fall out of the chain tail as left-aligned readback words.
module sb_ccff_loader #(
  parameter int unsigned CHAIN_LEN = 48,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic                abort,
  sb_ccff_loader_if.slave     bus,
  output logic                ccff_head,
  output logic                ccff_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WB_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] rbreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WB_W-1:0]   wbit;
  logic              cfg_ready_q;
  logic              rb_valid_q;
  logic [WORD_W-1:0] rb_data_q;

  logic [WORD_W-1:0] rb_next;
  logic [WORD_W-1:0] rb_align;
  logic [WB_W-1:0]   shamt;
  logic              word_last;

  assign ccff_head     = shreg[WORD_W-1];
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.rb_valid  = rb_valid_q;
  assign bus.rb_data   = rb_data_q;

  // Readback word as it will look after this shift; the last word may be short.
  always_comb begin
    rb_next   = WORD_W'({rbreg, ccff_tail});
    shamt     = WB_W'(WORD_W) - (wbit + WB_W'(1));
    rb_align  = rb_next << shamt;
    word_last = (wbit == WB_LAST) || (bit_cnt == CNT_LAST);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state       <= IDLE;
      shreg       <= '0;
      rbreg       <= '0;
      bit_cnt     <= '0;
      wbit        <= '0;
      cfg_ready_q <= 1'b0;
      rb_valid_q  <= 1'b0;
      rb_data_q   <= '0;
      ccff_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      cfg_ready_q <= 1'b0;
      rb_valid_q  <= 1'b0;
      ccff_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            cfg_ready_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.cfg_valid && cfg_ready_q) begin
            state       <= SHIFT;
            shreg       <= bus.cfg_data;
            rbreg       <= '0;
            wbit        <= '0;
            cfg_ready_q <= 1'b0;
            ccff_en     <= 1'b1;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          rbreg   <= rb_next;
          wbit    <= wbit + WB_W'(1);
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (word_last) begin
            state      <= DRAIN;
            ccff_en    <= 1'b0;
            rb_valid_q <= 1'b1;
            rb_data_q  <= rb_align;
          end
        end
        DRAIN: begin
          if (bus.rb_ready) begin
            rb_valid_q <= 1'b0;
            if (bit_cnt == CNT_FULL) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FETCH;
              cfg_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          cfg_ready_q <= 1'b0;
          rb_valid_q  <= 1'b0;
          ccff_en     <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sb_ccff_loader.md
# sb_ccff_loader

Bitstream loader and readback controller for the switch-block configuration chain, such as the 48-bit `ccff_head`→`ccff_tail` chain of a 1×1 switch block (eight 6-bit mux memories). It accepts configuration words from a host over a valid/ready stream and serializes them onto `ccff_head` under a shift enable that drives the chain's clock gate. It captures the bits leaving `ccff_tail` into readback words, so reloading a block returns its previous contents. It sits between the fabric configuration port and one tile's chain, on `prog_clk`.

## Interface
- `CHAIN_LEN`, default 48: number of flops in the chain; must be ≥1.
- `WORD_W`, default 8: host word width; must be ≥1.
- `prog_clk` in 1: the only clock; all logic is on the rising edge.
- `pReset` in 1: synchronous, active-high reset.
- `start` in 1: begins a load when the block is IDLE; ignored in any other state.
- `abort` in 1: synchronous cancel; returns the block to IDLE.
- `cfg_data` in WORD_W: bitstream word; the MSB is shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: block accepts a word this cycle.
- `ccff_head` out 1: serial bit to the chain input.
- `ccff_en` out 1: chain shift enable; the chain shifts on each edge where it is 1.
- `ccff_tail` in 1: chain output.
- `rb_data` out WORD_W: readback word, left-aligned.
- `rb_valid` out 1: readback word available.
- `rb_ready` in 1: consumer accepts the readback word.
- `busy` out 1: block is in any state other than IDLE.
- `done` out 1: one-cycle pulse when a load completes.

## Operation
- Word count is NW = ceil(CHAIN_LEN/WORD_W). Each word shifts min(WORD_W, remaining) bits. Unused low bits of the last word are discarded.
- Registers:
  - `shreg` (WORD_W bits)
  - `rbreg` (WORD_W bits)
  - `bit_cnt`, clog2(CHAIN_LEN+1) bits: total bits shifted
  - `wbit`, clog2(WORD_W+1) bits: bits shifted in the current word
- `ccff_head` = `shreg[WORD_W-1]`, combinational from the register.
- `ccff_en` = (state == SHIFT).
- States:
  - IDLE: `start`=1 → FETCH; clear `bit_cnt`.
  - FETCH: `cfg_ready`=1. On `cfg_valid` & `cfg_ready`: load `shreg`, clear `wbit` and `rbreg` → SHIFT.
  - SHIFT: on each edge, `shreg` <<= 1, `rbreg` <= {`rbreg[WORD_W-2:0]`, `ccff_tail`}, `wbit`++, `bit_cnt`++. When the bit just shifted completes the word (`wbit`+1 == min(WORD_W, CHAIN_LEN − word base)) → DRAIN.
  - DRAIN: `rb_valid`=1, `rb_data` = `rbreg` shifted left by (WORD_W − bits shifted in this word), zero-filled below. On `rb_ready`: if `bit_cnt` == CHAIN_LEN → DONE, else → FETCH.
  - DONE: `done`=1 for one cycle → IDLE.
- The first bit shifted ends up deepest in the chain (nearest `ccff_tail`) after CHAIN_LEN shifts.
- Readback bit k is the `ccff_tail` value sampled at shift edge k. When CHAIN_LEN is a multiple of WORD_W, readback word i equals host word i of the previous load.
- Stalls:
  - `cfg_valid`=0 in FETCH or `rb_ready`=0 in DRAIN holds state.
  - `ccff_en`=0 throughout a stall, so chain contents are frozen.
- Simultaneous events:
  - `abort` wins over every other input.
  - `pReset` wins over `abort`.

## Timing
- Reset values: state IDLE, and `cfg_ready`, `ccff_en`, `ccff_head`, `rb_valid`, `rb_data`, `busy`, `done` all 0; all counters 0.
- `start` sampled high at edge t → `busy`=1 and `cfg_ready`=1 from cycle t+1.
- A word accepted at edge a:
  - `ccff_en`=1 for cycles a+1 … a+WORD_W (full word).
  - `rb_valid`=1 from cycle a+WORD_W+1.
- With `cfg_valid` and `rb_ready` held high, each full word takes WORD_W+2 cycles.
- Default parameters: `done` pulses exactly 60 cycles after the `start` edge's FETCH entry (6 words × 10 cycles); IDLE on the following cycle.
- `abort` or `pReset` at edge t:
  - From cycle t+1: `ccff_en`=0, `cfg_ready`=0, `rb_valid`=0, `busy`=0, no `done` pulse.
  - Chain contents are partial and undefined.
  - A new `start` is accepted the cycle after.
- `rb_data` is stable while `rb_valid`=1 and `rb_ready`=0.
- `cfg_data` is sampled only on an accepting edge.

## Test plan
- Reset: assert `pReset` mid-SHIFT with a word in flight → next cycle all outputs 0 and state IDLE. Then apply `start` → `cfg_ready`=1 one cycle later.
- Full load (defaults, behavioural 48-flop chain model, source and sink always ready): words 0xA5, 0x3C, 0xFF, 0x00, 0x81, 0x7E.
  - Model bits[47:0] = 0xA53CFF00817E, with the first-shifted bit at the tail.
  - `done` pulses 60 cycles after FETCH entry.
  - Exactly 48 cycles have `ccff_en`=1.
- Readback: reload with 0x11…0x66 → `rb_data` sequence = 0xA5, 0x3C, 0xFF, 0x00, 0x81, 0x7E. Model then holds 0x112233445566.
- Stalls: drop `cfg_valid` for 5 cycles before word 3 and `rb_ready` for 4 cycles in DRAIN of word 2.
  - `ccff_en`=0 throughout both stalls.
  - `rb_data` holds its value during the `rb_ready` stall.
  - Final chain content is identical to the no-stall run.
  - Total time is 9 cycles longer.
- Partial last word (CHAIN_LEN=13, WORD_W=8): load 0xF0, 0xA8 into a chain preset to all ones.
  - Only 5 bits of the second word are shifted, 13 `ccff_en` cycles in total.
  - Readback is 0xFF then 0xF8.
- Abort during word 3 SHIFT → next cycle `ccff_en`=0 and `busy`=0, no `done`. A following full load completes normally with correct chain content.
